// File: rtl/ch2_arb_pkg.sv
// Shared types and constants for the SDRAM channel-2 save arbiter.
//   arb_state_e : arbiter FSM states (also exported on the debug port)
//   grant_e     : which requester currently owns / last owned the channel
//   SAVE_BASE_DEFAULT : upper address bits of the backup-RAM region
//   ERR_RDATA   : read data returned when a transaction is aborted
package ch2_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_WAIT_RISE = 3'd2,
        ST_WAIT_FALL = 3'd3,
        ST_ACK       = 3'd4,
        ST_GAP       = 3'd5
    } arb_state_e;

    typedef enum logic {
        GNT_SAVE = 1'b0,
        GNT_SS   = 1'b1
    } grant_e;

    localparam logic [6:0] SAVE_BASE_DEFAULT = 7'b0001111;
    localparam logic [7:0] ERR_RDATA         = 8'hFF;

endpackage

// File: rtl/ch2_strobe_gen.sv
// Strobe generator for the SDRAM channel-2 port.
// Raises exactly one rd or wr strobe per attempt, only on a cycle where the
// controller is not busy, and watches for busy to rise. If busy does not rise
// within BUSY_TIMEOUT cycles the strobe is dropped and the attempt is retried;
// after MAX_RETRY reissues the transaction is aborted.
// Ports:
//   clk_i, rst_ni        : clock, async active-low reset
//   clear_i              : arbiter idle, reset the retry budget
//   issue_i, wait_rise_i : arbiter is in ISSUE / WAIT_RISE
//   we_i                 : 1 = write strobe, 0 = read strobe
//   busy_i               : controller busy
//   rd_o, wr_o           : registered strobes
//   fire_o               : strobe launched this cycle (ISSUE -> WAIT_RISE)
//   rise_o               : busy seen high (WAIT_RISE -> WAIT_FALL)
//   timeout_o            : attempt timed out, reissue (WAIT_RISE -> ISSUE)
//   abort_o              : retries exhausted (WAIT_RISE -> ACK with error)
module ch2_strobe_gen #(
    parameter int BUSY_TIMEOUT = 4,
    parameter int MAX_RETRY    = 3
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic issue_i,
    input  logic wait_rise_i,
    input  logic we_i,
    input  logic busy_i,
    output logic rd_o,
    output logic wr_o,
    output logic fire_o,
    output logic rise_o,
    output logic timeout_o,
    output logic abort_o
);

    localparam int CW = $clog2(BUSY_TIMEOUT + 1);
    localparam int RW = $clog2(MAX_RETRY + 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(BUSY_TIMEOUT - 1);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

    logic          rd_q, rd_d;
    logic          wr_q, wr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [RW-1:0] retry_q, retry_d;

    always_comb begin
        rd_d      = rd_q;
        wr_d      = wr_q;
        cnt_d     = cnt_q;
        retry_d   = retry_q;
        fire_o    = 1'b0;
        rise_o    = 1'b0;
        timeout_o = 1'b0;
        abort_o   = 1'b0;

        if (clear_i) begin
            rd_d    = 1'b0;
            wr_d    = 1'b0;
            cnt_d   = '0;
            retry_d = '0;
        end

        // The controller only sees a rising edge on a non-busy cycle.
        if (issue_i && !busy_i) begin
            fire_o = 1'b1;
            rd_d   = ~we_i;
            wr_d   = we_i;
            cnt_d  = '0;
        end

        if (wait_rise_i) begin
            if (busy_i) begin
                rise_o = 1'b1;
                rd_d   = 1'b0;
                wr_d   = 1'b0;
            end else if (cnt_q == CNT_LAST) begin
                // Dropping the strobe here and refiring from ISSUE gives
                // the single low cycle the controller needs to see a new edge.
                rd_d = 1'b0;
                wr_d = 1'b0;
                if (retry_q == RETRY_MAX) begin
                    abort_o = 1'b1;
                end else begin
                    timeout_o = 1'b1;
                    retry_d   = retry_q + RW'(1);
                end
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            cnt_q   <= '0;
            retry_q <= '0;
        end else begin
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            cnt_q   <= cnt_d;
            retry_q <= retry_d;
        end
    end

    assign rd_o = rd_q;
    assign wr_o = wr_q;

endmodule

// File: rtl/ch2_save_arbiter.sv
// Arbiter sharing SDRAM channel 2 (backup-RAM region) between the save-file
// bridge (sv_*) and the savestate engine (ss_*), clk_85_9 domain.
// Handshake: a requester raises req with we/addr/wdata stable and holds it
// until it sees a one-cycle ack; rdata is valid in the ack cycle. After ack
// the arbiter ignores requests for two GAP cycles so req can be lowered.
// Ports:
//   clk_85_9, reset_n        : clock, async active-low reset
//   sleep_savestate          : savestate engine owns the channel exclusively
//   sv_* / ss_*              : save / savestate request ports
//   ch2_*                    : SDRAM controller channel-2 port
//   arb_busy                 : arbiter not idle
//   arb_error                : sticky abort flag, cleared only by reset
//   dbg_state                : current FSM state
module ch2_save_arbiter
    import ch2_arb_pkg::*;
#(
    parameter logic [6:0] SAVE_BASE    = SAVE_BASE_DEFAULT,
    parameter int         BUSY_TIMEOUT = 4,
    parameter int         MAX_RETRY    = 3
) (
    input  logic        clk_85_9,
    input  logic        reset_n,
    input  logic        sleep_savestate,
    input  logic        sv_req,
    input  logic        sv_we,
    input  logic [17:0] sv_addr,
    input  logic [7:0]  sv_wdata,
    output logic        sv_ack,
    output logic [7:0]  sv_rdata,
    input  logic        ss_req,
    input  logic        ss_we,
    input  logic [24:0] ss_addr,
    input  logic [7:0]  ss_wdata,
    output logic        ss_ack,
    output logic [7:0]  ss_rdata,
    output logic [24:0] ch2_addr,
    output logic [7:0]  ch2_din,
    output logic        ch2_rd,
    output logic        ch2_wr,
    input  logic [7:0]  ch2_dout,
    input  logic        ch2_busy,
    output logic        arb_busy,
    output logic        arb_error,
    output arb_state_e  dbg_state
);

    arb_state_e  state_q, state_d;
    grant_e      grant_q, grant_d;      // doubles as the round-robin pointer
    logic        we_q, we_d;
    logic [24:0] addr_q, addr_d;
    logic [7:0]  din_q, din_d;
    logic        sv_ack_q, sv_ack_d;
    logic        ss_ack_q, ss_ack_d;
    logic [7:0]  sv_rdata_q, sv_rdata_d;
    logic [7:0]  ss_rdata_q, ss_rdata_d;
    logic        err_q, err_d;
    logic        gap_q, gap_d;
    logic        arb_busy_q;

    logic        sv_ok, ss_ok, finish;
    logic [7:0]  fin_data;
    logic        fire, rise, timeout, abort;

    ch2_strobe_gen #(
        .BUSY_TIMEOUT (BUSY_TIMEOUT),
        .MAX_RETRY    (MAX_RETRY)
    ) u_strobe (
        .clk_i       (clk_85_9),
        .rst_ni      (reset_n),
        .clear_i     (state_q == ST_IDLE),
        .issue_i     (state_q == ST_ISSUE),
        .wait_rise_i (state_q == ST_WAIT_RISE),
        .we_i        (we_q),
        .busy_i      (ch2_busy),
        .rd_o        (ch2_rd),
        .wr_o        (ch2_wr),
        .fire_o      (fire),
        .rise_o      (rise),
        .timeout_o   (timeout),
        .abort_o     (abort)
    );

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        we_d       = we_q;
        addr_d     = addr_q;
        din_d      = din_q;
        sv_ack_d   = 1'b0;
        ss_ack_d   = 1'b0;
        sv_rdata_d = sv_rdata_q;
        ss_rdata_d = ss_rdata_q;
        err_d      = err_q;
        gap_d      = gap_q;
        finish     = 1'b0;
        fin_data   = ch2_dout;
        // While the savestate engine sleeps the core, a save request is
        // simply left pending rather than dropped.
        sv_ok      = sv_req & ~sleep_savestate;
        ss_ok      = ss_req;

        unique case (state_q)
            ST_IDLE: begin
                if (ss_ok && (!sv_ok || grant_q == GNT_SAVE)) begin
                    grant_d = GNT_SS;
                    we_d    = ss_we;
                    addr_d  = ss_addr;
                    din_d   = ss_wdata;
                    state_d = ST_ISSUE;
                end else if (sv_ok) begin
                    grant_d = GNT_SAVE;
                    we_d    = sv_we;
                    addr_d  = {SAVE_BASE, sv_addr};
                    din_d   = sv_wdata;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (fire) state_d = ST_WAIT_RISE;
            end
            ST_WAIT_RISE: begin
                if (rise) begin
                    state_d = ST_WAIT_FALL;
                end else if (abort) begin
                    err_d    = 1'b1;
                    finish   = 1'b1;
                    fin_data = ERR_RDATA;
                end else if (timeout) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_WAIT_FALL: begin
                if (!ch2_busy) finish = 1'b1;
            end
            ST_ACK: begin
                gap_d   = 1'b0;
                state_d = ST_GAP;
            end
            ST_GAP: begin
                if (gap_q) state_d = ST_IDLE;
                else       gap_d   = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase

        if (finish) begin
            state_d = ST_ACK;
            if (grant_q == GNT_SS) begin
                ss_ack_d   = 1'b1;
                ss_rdata_d = fin_data;
            end else begin
                sv_ack_d   = 1'b1;
                sv_rdata_d = fin_data;
            end
        end
    end

    always_ff @(posedge clk_85_9 or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            grant_q    <= GNT_SAVE;
            we_q       <= 1'b0;
            addr_q     <= '0;
            din_q      <= '0;
            sv_ack_q   <= 1'b0;
            ss_ack_q   <= 1'b0;
            sv_rdata_q <= '0;
            ss_rdata_q <= '0;
            err_q      <= 1'b0;
            gap_q      <= 1'b0;
            arb_busy_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            din_q      <= din_d;
            sv_ack_q   <= sv_ack_d;
            ss_ack_q   <= ss_ack_d;
            sv_rdata_q <= sv_rdata_d;
            ss_rdata_q <= ss_rdata_d;
            err_q      <= err_d;
            gap_q      <= gap_d;
            arb_busy_q <= (state_d != ST_IDLE);
        end
    end

    assign ch2_addr  = addr_q;
    assign ch2_din   = din_q;
    assign sv_ack    = sv_ack_q;
    assign ss_ack    = ss_ack_q;
    assign sv_rdata  = sv_rdata_q;
    assign ss_rdata  = ss_rdata_q;
    assign arb_busy  = arb_busy_q;
    assign arb_error = err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_ch2_save_arbiter.sv
module tb_ch2_save_arbiter;
    import ch2_arb_pkg::*;

    localparam int W = 9;                       // {granted_is_ss, rdata}
    localparam logic [6:0] TB_SAVE_BASE = 7'b0001111;

    logic        clk_85_9 = 1'b0;
    logic        reset_n;
    logic        sleep_savestate;
    logic        sv_req, sv_we;
    logic [17:0] sv_addr;
    logic [7:0]  sv_wdata;
    logic        sv_ack;
    logic [7:0]  sv_rdata;
    logic        ss_req, ss_we;
    logic [24:0] ss_addr;
    logic [7:0]  ss_wdata;
    logic        ss_ack;
    logic [7:0]  ss_rdata;
    logic [24:0] ch2_addr;
    logic [7:0]  ch2_din;
    logic        ch2_rd, ch2_wr;
    logic [7:0]  ch2_dout;
    logic        ch2_busy;
    logic        arb_busy, arb_error;
    arb_state_e  dbg_state;

    // ---------------- clock / reset ----------------
    always #5 clk_85_9 = ~clk_85_9;

    int cyc = 0;
    always @(posedge clk_85_9) cyc <= cyc + 1;

    ch2_save_arbiter dut (
        .clk_85_9        (clk_85_9),
        .reset_n         (reset_n),
        .sleep_savestate (sleep_savestate),
        .sv_req          (sv_req),
        .sv_we           (sv_we),
        .sv_addr         (sv_addr),
        .sv_wdata        (sv_wdata),
        .sv_ack          (sv_ack),
        .sv_rdata        (sv_rdata),
        .ss_req          (ss_req),
        .ss_we           (ss_we),
        .ss_addr         (ss_addr),
        .ss_wdata        (ss_wdata),
        .ss_ack          (ss_ack),
        .ss_rdata        (ss_rdata),
        .ch2_addr        (ch2_addr),
        .ch2_din         (ch2_din),
        .ch2_rd          (ch2_rd),
        .ch2_wr          (ch2_wr),
        .ch2_dout        (ch2_dout),
        .ch2_busy        (ch2_busy),
        .arb_busy        (arb_busy),
        .arb_error       (arb_error),
        .dbg_state       (dbg_state)
    );

    // ---------------- SDRAM controller model ----------------
    // Accepts a rising strobe seen on a non-busy edge, then holds busy for
    // busy_len cycles. Read data is a fixed function of the address.
    function automatic logic [7:0] mdl_data(input logic [24:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    logic        prev_stb, mdl_busy, ext_busy;
    int          busy_left, busy_len;
    bit          respond;
    int          wr_edges = 0, rd_edges = 0;
    logic [24:0] last_addr;
    logic [7:0]  last_din;

    assign ch2_busy = mdl_busy | ext_busy;

    always @(posedge clk_85_9 or negedge reset_n) begin
        if (!reset_n) begin
            prev_stb  <= 1'b0;
            mdl_busy  <= 1'b0;
            busy_left <= 0;
            ch2_dout  <= 8'h00;
        end else begin
            prev_stb <= ch2_rd | ch2_wr;
            if ((ch2_rd | ch2_wr) && !prev_stb) begin
                if (ch2_wr) wr_edges <= wr_edges + 1;
                else        rd_edges <= rd_edges + 1;
                last_addr <= ch2_addr;
                last_din  <= ch2_din;
            end
            if (busy_left != 0) begin
                busy_left <= busy_left - 1;
                if (busy_left == 1) mdl_busy <= 1'b0;
            end else if ((ch2_rd | ch2_wr) && !prev_stb && !ch2_busy && respond) begin
                mdl_busy  <= 1'b1;
                busy_left <= busy_len;
                ch2_dout  <= mdl_data(ch2_addr);
            end
        end
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;
    int ack_cnt  = 0;
    logic [W-1:0] exp_q[$];
    bit tb_last_ss = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input bit is_ss, input logic [24:0] full_addr, input bit resp);
        exp_q.push_back({is_ss, resp ? mdl_data(full_addr) : 8'hFF});
        tb_last_ss = is_ss;
    endtask

    // Scoreboard: every ack must match the oldest expected grant/rdata.
    always @(negedge clk_85_9) begin
        logic [W-1:0] got, exp;
        if (reset_n && (sv_ack || ss_ack)) begin
            ack_cnt++;
            chk("ack_onehot", 32'(sv_ack & ss_ack), 32'd0);
            chk("ack_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                exp = exp_q.pop_front();
                got = {ss_ack, ss_ack ? ss_rdata : sv_rdata};
                chk("ack_grant_rdata", 32'(got), 32'(exp));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_ack(output bit got_ss);
        bit ok = 1'b0;
        got_ss = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk_85_9);
            if (sv_ack || ss_ack) begin
                got_ss = ss_ack;
                ok     = 1'b1;
                break;
            end
        end
        chk("ack_within_budget", 32'(ok), 32'd1);
    endtask

    task automatic do_req(input bit is_ss, input bit we, input logic [24:0] a,
                          input logic [7:0] wd, input bit resp, output int lat);
        bit got_ss;
        int c0;
        @(negedge clk_85_9);
        push_exp(is_ss, is_ss ? a : {TB_SAVE_BASE, a[17:0]}, resp);
        if (is_ss) begin
            ss_req = 1'b1; ss_we = we; ss_addr = a; ss_wdata = wd;
        end else begin
            sv_req = 1'b1; sv_we = we; sv_addr = a[17:0]; sv_wdata = wd;
        end
        c0 = cyc;
        wait_ack(got_ss);
        lat = cyc - c0;
        sv_req = 1'b0;
        ss_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // ---------------- directed sequence ----------------
    initial begin
        int  lat, e0, a0;
        bit  got_ss, nxt;
        logic [17:0] sv_a;
        logic [24:0] ss_a;

        reset_n = 1'b0; sleep_savestate = 1'b0;
        sv_req = 1'b0; sv_we = 1'b0; sv_addr = '0; sv_wdata = '0;
        ss_req = 1'b0; ss_we = 1'b0; ss_addr = '0; ss_wdata = '0;
        ext_busy = 1'b0; respond = 1'b1; busy_len = 3;

        repeat (3) @(negedge clk_85_9);
        reset_n = 1'b1;
        @(negedge clk_85_9);
        chk("rst_arb_busy", 32'(arb_busy), 32'd0);
        chk("rst_arb_error", 32'(arb_error), 32'd0);
        chk("rst_strobes", 32'({ch2_rd, ch2_wr}), 32'd0);
        chk("rst_acks", 32'({sv_ack, ss_ack}), 32'd0);
        chk("rst_ch2_addr", 32'(ch2_addr), 32'd0);

        // Save write, busy lasts 3 cycles: latency 4 + 3.
        e0 = wr_edges; a0 = rd_edges;
        do_req(1'b0, 1'b1, 25'h0000010, 8'hA5, 1'b1, lat);
        chk("sv_wr_latency", 32'(lat), 32'd7);
        chk("sv_wr_addr", 32'(last_addr), 32'h03C0010);
        chk("sv_wr_din", 32'(last_din), 32'hA5);
        chk("sv_wr_edges", 32'(wr_edges - e0), 32'd1);
        chk("sv_wr_no_rd", 32'(rd_edges - a0), 32'd0);

        // Savestate read while sleeping.
        sleep_savestate = 1'b1;
        do_req(1'b1, 1'b0, 25'h1000000, 8'h00, 1'b1, lat);
        chk("ss_rd_rdata", 32'(ss_rdata), 32'h5A);
        chk("ss_rd_addr", 32'(last_addr), 32'h1000000);
        sleep_savestate = 1'b0;

        // Contention without sleep: round-robin alternation.
        sv_a = 18'h00123; ss_a = 25'h0000456;
        nxt = ~tb_last_ss;
        for (int k = 0; k < 3; k++) begin
            push_exp(nxt, nxt ? ss_a : {TB_SAVE_BASE, sv_a}, 1'b1);
            nxt = ~nxt;
        end
        @(negedge clk_85_9);
        sv_req = 1'b1; sv_we = 1'b0; sv_addr = sv_a;
        ss_req = 1'b1; ss_we = 1'b0; ss_addr = ss_a;
        repeat (3) wait_ack(got_ss);
        sv_req = 1'b0; ss_req = 1'b0;

        // Contention with sleep: savestate only, save waits for sleep to drop.
        push_exp(1'b1, ss_a, 1'b1);
        push_exp(1'b1, ss_a, 1'b1);
        push_exp(1'b0, {TB_SAVE_BASE, sv_a}, 1'b1);
        @(negedge clk_85_9);
        sleep_savestate = 1'b1;
        sv_req = 1'b1; ss_req = 1'b1;
        wait_ack(got_ss);
        wait_ack(got_ss);
        ss_req = 1'b0; sleep_savestate = 1'b0;
        wait_ack(got_ss);
        sv_req = 1'b0;

        // Busy already high when the request arrives.
        busy_len = 2;
        e0 = rd_edges + wr_edges;
        @(negedge clk_85_9);
        ext_busy = 1'b1;
        push_exp(1'b0, {TB_SAVE_BASE, 18'h2BEEF}, 1'b1);
        sv_req = 1'b1; sv_we = 1'b0; sv_addr = 18'h2BEEF;
        repeat (10) @(negedge clk_85_9);
        chk("busy_no_edge", 32'(rd_edges + wr_edges - e0), 32'd0);
        chk("busy_strobe_low", 32'({ch2_rd, ch2_wr}), 32'd0);
        ext_busy = 1'b0;
        wait_ack(got_ss);
        sv_req = 1'b0;
        chk("busy_one_edge", 32'(rd_edges + wr_edges - e0), 32'd1);

        // Timeout: controller never answers.
        respond = 1'b0;
        chk("to_error_before", 32'(arb_error), 32'd0);
        e0 = rd_edges + wr_edges;
        do_req(1'b1, 1'b0, 25'h0001234, 8'h00, 1'b0, lat);
        chk("to_strobe_count", 32'(rd_edges + wr_edges - e0), 32'd4);
        chk("to_error_set", 32'(arb_error), 32'd1);
        repeat (3) @(negedge clk_85_9);
        chk("to_back_idle", 32'(arb_busy), 32'd0);
        respond = 1'b1;

        // Async reset while waiting for busy to fall.
        busy_len = 8;
        @(negedge clk_85_9);
        sv_req = 1'b1; sv_we = 1'b0; sv_addr = 18'h3ABCD;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk_85_9);
            if (dbg_state == ST_WAIT_FALL) break;
        end
        chk("rr_reached_wait_fall", 32'(dbg_state == ST_WAIT_FALL), 32'd1);
        chk("rr_error_sticky", 32'(arb_error), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("rr_arb_busy", 32'(arb_busy), 32'd0);
        chk("rr_strobes", 32'({ch2_rd, ch2_wr}), 32'd0);
        chk("rr_acks", 32'({sv_ack, ss_ack}), 32'd0);
        chk("rr_error_cleared", 32'(arb_error), 32'd0);
        sv_req = 1'b0;
        repeat (2) @(negedge clk_85_9);
        reset_n = 1'b1;
        a0 = ack_cnt;
        repeat (15) @(negedge clk_85_9);
        chk("rr_no_ack_after", 32'(ack_cnt - a0), 32'd0);
        busy_len = 1;
        do_req(1'b0, 1'b1, 25'h0000777, 8'h3C, 1'b1, lat);
        chk("rr_fresh_latency", 32'(lat), 32'd5);
        chk("rr_fresh_din", 32'(last_din), 32'h3C);

        repeat (4) @(negedge clk_85_9);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
